mux8_rr_sched: RTL
==================

// Module: mux8_rr_sched
// PURPOSE
//  Round-robin scheduler sharing the 8-bit 8:1 mux (MUX8T1_8) among 8 requesters.
//  Drives the mux select s[2:0] and returns a one-hot grant to each source.
//  A grant is held until the owner releases it or a hold limit expires.
//  Sits between the source request lines and the mux s input.
// PARAMETERS
//  MAX_HOLD  16  max cycles one grant is held; 0 = unlimited
//  HOLD_W    5   width of hold counter; must satisfy 2^HOLD_W > MAX_HOLD
// PORTS
//  clk      in   1  rising-edge clock
//  rst_n    in   1  asynchronous active-low reset
//  req      in   8  req[i]=1: source i wants the mux; level, held while needed
//  done     in   1  current owner releases grant this cycle (ignored in IDLE)
//  gnt      out  8  one-hot grant, registered; all-zero when idle
//  s        out  3  mux select = index of gnt bit; holds last value when idle
//  valid    out  1  =|gnt; mux output belongs to a granted source
//  timeout  out  1  1-cycle pulse: grant revoked by MAX_HOLD expiry
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, s=0, valid=0, timeout=0, ptr=0, hold_cnt=0,
//   state=IDLE. Takes effect mid-grant immediately; no release handshake.
//  State: IDLE, GRANT. ptr[2:0] = search start; hold_cnt counts owned cycles.
//  Winner search: first i with req[i]=1 scanning ptr, ptr+1, ... ptr+7 (mod 8).
//  IDLE: if |req, next edge: gnt<=onehot(w), s<=w, valid<=1, hold_cnt<=0,
//   -> GRANT. Latency req->gnt = 1 cycle. Else stay, outputs unchanged.
//  GRANT (owner k): release condition R = done | ~req[k] |
//   (MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1). If ~R: hold, hold_cnt++.
//  On R: ptr<=k+1 (wraps 7->0); winner re-searched from k+1 using current req
//   with req[k] masked only if done or ~req[k]; on timeout k stays eligible
//   but is scanned last (regranted only if sole requester).
//   Winner exists -> gnt switches next edge, no idle bubble, hold_cnt<=0.
//   None -> gnt<=0, valid<=0, s unchanged, -> IDLE.
//  timeout<=1 on the edge following an R caused only by hold expiry (done=0,
//   req[k]=1); 0 otherwise.
//  Simultaneous done and timeout: treated as done, timeout stays 0.
//  req changes on non-owners during GRANT: no effect until release.
//  gnt is always one-hot or zero; s == index(gnt) whenever valid=1.
//  hold_cnt saturates when MAX_HOLD=0 (no wrap-induced release).
// TESTING
//  1 reset: rst_n=0 with req=8'hFF -> gnt=0,s=0,valid=0; release -> gnt=01,s=0
//    one cycle later.
//  2 rotation: req=8'hFF, done pulsed each grant -> s sequence 0,1,..,7,0;
//    each granted source's mux I-value appears on o.
//  3 wrap/priority: ptr=6 (after owner 5 releases), req=8'h05 -> gnt=01 (s=0),
//    then owner 0 done -> gnt=04 (s=2).
//  4 timeout: MAX_HOLD=16, req=8'h09, no done -> owner 0 held exactly 16
//    cycles, timeout pulse, gnt=08 (s=3) next cycle, no bubble.
//  5 sole requester timeout: req=8'h10 constant -> regranted to 4 every 16
//    cycles, timeout pulses, valid never drops.
//  6 drop & reset mid-grant: owner 2 drops req, req=0 -> gnt=0, valid=0, s=2
//    held; assert rst_n=0 mid-GRANT -> outputs zero same cycle, ptr=0.

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin owner of an 8:1 mux: a source keeps its grant until it finishes,
// drops its request, or the hold limit runs out; then the next requester is granted.
module mux8_rr_sched #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic [2:0] s_o,
  output logic       valid_o,
  output logic       timeout_o
);

  // state   | meaning
  // S_IDLE  | no owner; the next requester is granted on the following edge
  // S_GRANT | source s_q owns the mux; hold_cnt_q counts the cycles it has owned it
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]        gnt_q, gnt_d;
  logic [2:0]        s_q, s_d;
  logic              timeout_q, timeout_d;

  logic [7:0] cand;
  logic [2:0] start;
  logic       win_found;
  logic [2:0] win_idx;
  logic       user_rel, expire;

  // First set bit of v, scanning upward from start and wrapping past 7.
  function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] st);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int i = 0; i < 8; i++) begin
      idx = st + 3'(i);
      if (!res[3] && v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= '0;
      gnt_q      <= 8'd0;
      s_q        <= 3'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      s_q        <= s_d;
      timeout_q  <= timeout_d;
    end
  end

  // A timed-out owner stays eligible; starting the scan at k+1 puts it last.
  always_comb begin
    user_rel = done_i | ~req_i[s_q];
    expire   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    if (state_q == S_IDLE) begin
      start = ptr_q;
      cand  = req_i;
    end else begin
      start = s_q + 3'd1;
      cand  = user_rel ? (req_i & ~(8'd1 << s_q)) : req_i;
    end
    {win_found, win_idx} = pick(cand, start);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    s_d        = s_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d      = 8'd1 << win_idx;
          s_d        = win_idx;
          hold_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!(user_rel || expire)) begin
          if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          ptr_d     = s_q + 3'd1;
          timeout_d = ~user_rel;
          if (win_found) begin
            gnt_d      = 8'd1 << win_idx;
            s_d        = win_idx;
            hold_cnt_d = '0;
          end else begin
            gnt_d   = 8'd0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o     = gnt_q;
    s_o       = s_q;
    valid_o   = |gnt_q;
    timeout_o = timeout_q;
  end

endmodule
